// File: rtl/pwr_seq_ctrl_if.sv
// Request and rail-control signals between the platform power logic and the sequencer.
interface pwr_seq_ctrl_if #(
  parameter int unsigned NUM_RAILS = 4,
  parameter int unsigned DLY_W     = 8
);
  logic                       iStart;
  logic                       iShutdown;
  logic [NUM_RAILS-1:0]       iPwrGood;
  logic [NUM_RAILS*DLY_W-1:0] iDelayMs;
  logic [NUM_RAILS-1:0]       oRailEn;
  logic                       oSysPwrOk;
  logic                       oFault;
  logic [2:0]                 oFaultRail;
  logic [2:0]                 oState;

  // Platform side: issues requests and reports rail status.
  modport master (
    output iStart, iShutdown, iPwrGood, iDelayMs,
    input  oRailEn, oSysPwrOk, oFault, oFaultRail, oState
  );

  // Sequencer side.
  modport slave (
    input  iStart, iShutdown, iPwrGood, iDelayMs,
    output oRailEn, oSysPwrOk, oFault, oFaultRail, oState
  );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// Power-rail sequencer: enables rails in index order, waits for power-good plus a
// per-rail delay, drops them in reverse order on shutdown, latches the failing rail.
module pwr_seq_ctrl #(
  parameter int unsigned multiplier = 2,
  parameter int unsigned UnitTime   = 1000,
  parameter int unsigned NUM_RAILS  = 4,
  parameter int unsigned DLY_W      = 8,
  parameter int unsigned TIMEOUT_MS = 10
) (
  input logic           iClk,
  input logic           iRst_n,
  pwr_seq_ctrl_if.slave bus
);

  localparam int unsigned TARGET = multiplier * UnitTime;
  localparam int unsigned TickW  = (TARGET > 1) ? $clog2(TARGET) : 1;
  localparam int unsigned ToW    = $clog2(TIMEOUT_MS + 1);
  localparam int unsigned MsW    = (DLY_W > ToW) ? DLY_W : ToW;
  localparam int unsigned IdxW   = $clog2(NUM_RAILS);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRamp  = 3'd1,
    StDelay = 3'd2,
    StOn    = 3'd3,
    StShdn  = 3'd4,
    StFault = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic [2:0]           fault_rail_q, fault_rail_d;
  logic [TickW-1:0]     tick_q;
  logic [MsW-1:0]       ms_q;

  logic                 tick, timeout, restart, pg_cur, ms_hit, last;
  logic [DLY_W-1:0]     dly_cur;
  logic [NUM_RAILS-1:0] accepted;
  logic                 loss;
  logic [IdxW-1:0]      loss_idx;

  assign tick    = (tick_q == TickW'(TARGET - 1));
  assign timeout = tick && (ms_q == MsW'(TIMEOUT_MS - 1));
  assign pg_cur  = bus.iPwrGood[idx_q];
  assign dly_cur = bus.iDelayMs[int'(idx_q) * DLY_W +: DLY_W];
  assign ms_hit  = (ms_q == MsW'(dly_cur));
  assign last    = (idx_q == IdxW'(NUM_RAILS - 1));
  // Any change of phase or rail starts a fresh interval with a full first ms.
  assign restart = (state_d != state_q) || (idx_d != idx_q);

  // Rail-loss monitor: lowest already-accepted rail whose power-good dropped.
  always_comb begin
    accepted = '0;
    loss     = 1'b0;
    loss_idx = '0;
    for (int j = 0; j < NUM_RAILS; j++) begin
      if (state_q == StRamp) begin
        accepted[j] = (j < int'(idx_q));
      end else if (state_q == StDelay || state_q == StOn) begin
        accepted[j] = (j <= int'(idx_q));
      end
    end
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (accepted[j] && !bus.iPwrGood[j]) begin
        loss     = 1'b1;
        loss_idx = IdxW'(j);
      end
    end
  end

  // Sequencer next-state, rail index, enables and fault capture.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rail_en_d    = rail_en_q;
    fault_rail_d = fault_rail_q;
    unique case (state_q)
      StIdle: begin
        if (bus.iStart && !bus.iShutdown) begin
          state_d      = StRamp;
          idx_d        = '0;
          fault_rail_d = '0;
        end
      end
      StRamp: begin
        if (loss) begin
          state_d      = StFault;
          fault_rail_d = 3'(loss_idx);
        end else if (timeout && !pg_cur) begin
          state_d      = StFault;
          fault_rail_d = 3'(idx_q);
        end else if (bus.iShutdown) begin
          state_d = StShdn;
        end else if (pg_cur) begin
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (loss) begin
          state_d      = StFault;
          fault_rail_d = 3'(loss_idx);
        end else if (bus.iShutdown) begin
          state_d = StShdn;
        end else if (ms_hit) begin
          if (last) begin
            state_d = StOn;
          end else begin
            state_d = StRamp;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      StOn: begin
        if (loss) begin
          state_d      = StFault;
          fault_rail_d = 3'(loss_idx);
        end else if (bus.iShutdown) begin
          state_d = StShdn;
        end
      end
      StShdn: begin
        if (rail_en_q == '0) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (tick) begin
          // Enables are always a contiguous run from rail 0, so a shift drops the top one.
          rail_en_d = rail_en_q >> 1;
        end
      end
      StFault: begin
        if (bus.iShutdown && !bus.iStart) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
    if (state_d == StFault) rail_en_d = '0;
    if (state_d == StRamp) rail_en_d[idx_d] = 1'b1;
  end

  // State, index, enable and fault-rail registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      rail_en_q    <= '0;
      fault_rail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rail_en_q    <= rail_en_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  // 1 ms tick generator and saturating ms counter, restarted on every phase change.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      tick_q <= '0;
      ms_q   <= '0;
    end else if (restart) begin
      tick_q <= '0;
      ms_q   <= '0;
    end else begin
      tick_q <= tick ? '0 : tick_q + 1'b1;
      if (tick && (ms_q != '1)) ms_q <= ms_q + 1'b1;
    end
  end

  assign bus.oRailEn    = rail_en_q;
  assign bus.oSysPwrOk  = (state_q == StOn);
  assign bus.oFault     = (state_q == StFault);
  assign bus.oFaultRail = fault_rail_q;
  assign bus.oState     = state_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl with a scoreboard of expected state/enable transitions.
module tb_pwr_seq_ctrl;

  localparam int unsigned NR = 4;

  typedef struct {
    logic [2:0] st;
    logic [3:0] en;
    int         cyc;
    string      tag;
  } exp_t;

  logic   iClk;
  logic   iRst_n;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  int     last_cyc = 0;
  logic [6:0] prev = '0;
  exp_t   sb_q[$];
  int     dly[4] = '{3, 0, 1, 2};

  pwr_seq_ctrl_if #(.NUM_RAILS(NR), .DLY_W(8)) bus ();

  pwr_seq_ctrl #(
    .multiplier(2),
    .UnitTime  (5),
    .NUM_RAILS (NR),
    .DLY_W     (8),
    .TIMEOUT_MS(3)
  ) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] en_mask(input int k);
    return 4'((1 << (k + 1)) - 1);
  endfunction

  task automatic push(input logic [2:0] st, input logic [3:0] en, input int c,
                      input string tag);
    exp_t e;
    e.st  = st;
    e.en  = en;
    e.cyc = c;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Wait for the next change of {state, enables} and compare it with the scoreboard head.
  task automatic expect_next(input int budget);
    exp_t       e;
    bit         seen;
    logic [38:0] obs;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge iClk);
      if ({bus.oState, bus.oRailEn} !== prev) seen = 1'b1;
    end
    n_cmp++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_underflow: got change st=%0d en=%b want none", bus.oState, bus.oRailEn);
      return;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      assert (seen) else begin
        n_fail++;
        $error("FAIL %s: got no transition within %0d cycles want st=%0d en=%b cyc=%0d",
               e.tag, budget, e.st, e.en, e.cyc);
      end
    end else begin
      obs = {bus.oState, bus.oRailEn, 32'(cyc)};
      assert (obs === {e.st, e.en, 32'(e.cyc)}) else begin
        n_fail++;
        $error("FAIL %s: got st=%0d en=%b cyc=%0d want st=%0d en=%b cyc=%0d",
               e.tag, bus.oState, bus.oRailEn, cyc, e.st, e.en, e.cyc);
      end
    end
    last_cyc = cyc;
    prev     = {bus.oState, bus.oRailEn};
  endtask

  // Assert rail k good 5 clocks after its enable, then expect DELAY and the next step.
  task automatic ramp_rail(input int k);
    int g;
    repeat (5) @(posedge iClk);
    #1;
    g = cyc;
    bus.iPwrGood[k] = 1'b1;
    push(3'd2, en_mask(k), g + 1, "delay_entry");
    expect_next(20);
    if (k < 3) push(3'd1, en_mask(k + 1), g + 2 + 10 * dly[k], "next_rail_en");
    else       push(3'd3, 4'hf, g + 2 + 10 * dly[k], "on_entry");
    expect_next(60);
  endtask

  initial begin
    int s;
    bus.iStart    = 1'b0;
    bus.iShutdown = 1'b0;
    bus.iPwrGood  = '0;
    bus.iDelayMs  = {8'd2, 8'd1, 8'd0, 8'd3};
    iRst_n        = 1'b1;
    #2 iRst_n     = 1'b0;
    #1;
    check("rst_state", bus.oState, 0);
    check("rst_en", bus.oRailEn, 0);
    check("rst_pwrok", bus.oSysPwrOk, 0);
    check("rst_fault", bus.oFault, 0);
    check("rst_fault_rail", bus.oFaultRail, 0);
    repeat (3) @(posedge iClk);
    #1 iRst_n = 1'b1;
    prev = {bus.oState, bus.oRailEn};

    // Normal power-up.
    @(posedge iClk); #1;
    s = cyc;
    bus.iStart = 1'b1;
    push(3'd1, 4'b0001, s + 1, "up_r0_en");
    expect_next(20);
    for (int k = 0; k < 4; k++) ramp_rail(k);
    check("on_pwrok", bus.oSysPwrOk, 1);
    check("on_fault", bus.oFault, 0);

    // Dropping iStart in ON has no effect.
    bus.iStart = 1'b0;
    repeat (15) @(posedge iClk);
    #1;
    check("on_hold_state", bus.oState, 3);

    // Rail loss on rails 1 and 3 together with shutdown: fault wins, lowest rail latched.
    s = cyc;
    bus.iStart    = 1'b1;
    bus.iShutdown = 1'b1;
    bus.iPwrGood  = 4'b0101;
    push(3'd5, 4'b0000, s + 1, "loss_fault");
    @(posedge iClk); #1;
    bus.iPwrGood = 4'b1111;
    expect_next(5);
    check("loss_rail", bus.oFaultRail, 1);
    check("loss_pwrok", bus.oSysPwrOk, 0);
    check("loss_fault", bus.oFault, 1);
    repeat (5) @(posedge iClk);
    #1;
    check("fault_hold_with_start", bus.oState, 5);

    // Fault clear needs iShutdown=1 and iStart=0; fault rail retained in IDLE.
    s = cyc;
    bus.iStart = 1'b0;
    push(3'd0, 4'b0000, s + 1, "fault_clear");
    expect_next(5);
    check("idle_keep_rail", bus.oFaultRail, 1);
    check("idle_fault", bus.oFault, 0);

    // iShutdown beats iStart in IDLE.
    bus.iStart = 1'b1;
    repeat (12) @(posedge iClk);
    #1;
    check("prio_state", bus.oState, 0);
    check("prio_en", bus.oRailEn, 0);

    // Restart clears fault rail; rail 2 times out.
    bus.iPwrGood = '0;
    s = cyc;
    bus.iShutdown = 1'b0;
    push(3'd1, 4'b0001, s + 1, "restart_r0_en");
    expect_next(5);
    check("restart_rail_clr", bus.oFaultRail, 0);
    ramp_rail(0);
    ramp_rail(1);
    push(3'd5, 4'b0000, last_cyc + 30, "timeout_fault");
    expect_next(40);
    check("timeout_rail", bus.oFaultRail, 2);
    check("timeout_fault", bus.oFault, 1);
    s = cyc;
    bus.iStart    = 1'b0;
    bus.iShutdown = 1'b1;
    push(3'd0, 4'b0000, s + 1, "timeout_clear");
    expect_next(5);

    // Full power-up, then shutdown from ON with rails losing good during SHDN.
    @(posedge iClk); #1;
    s = cyc;
    bus.iPwrGood  = '0;
    bus.iStart    = 1'b1;
    bus.iShutdown = 1'b0;
    push(3'd1, 4'b0001, s + 1, "up2_r0_en");
    expect_next(5);
    for (int k = 0; k < 4; k++) ramp_rail(k);
    check("up2_pwrok", bus.oSysPwrOk, 1);
    @(posedge iClk); #1;
    s = cyc;
    bus.iShutdown = 1'b1;
    push(3'd4, 4'b1111, s + 1, "shdn_entry");
    push(3'd4, 4'b0111, s + 11, "shdn_r3_off");
    push(3'd4, 4'b0011, s + 21, "shdn_r2_off");
    push(3'd4, 4'b0001, s + 31, "shdn_r1_off");
    push(3'd4, 4'b0000, s + 41, "shdn_r0_off");
    push(3'd0, 4'b0000, s + 42, "shdn_idle");
    expect_next(5);
    bus.iPwrGood = '0;
    for (int i = 0; i < 5; i++) expect_next(15);

    // Reset mid-DELAY, then a fresh start shows full tick spacing via rail 0 timeout.
    @(posedge iClk); #1;
    s = cyc;
    bus.iShutdown = 1'b0;
    push(3'd1, 4'b0001, s + 1, "pre_rst_r0_en");
    expect_next(5);
    repeat (5) @(posedge iClk);
    #1;
    s = cyc;
    bus.iPwrGood[0] = 1'b1;
    push(3'd2, 4'b0001, s + 1, "pre_rst_delay");
    expect_next(5);
    repeat (5) @(posedge iClk);
    #1 iRst_n = 1'b0;
    #1;
    check("async_rst_en", bus.oRailEn, 0);
    check("async_rst_state", bus.oState, 0);
    check("async_rst_pwrok", bus.oSysPwrOk, 0);
    check("async_rst_fault", bus.oFault, 0);
    prev = {bus.oState, bus.oRailEn};
    bus.iPwrGood = '0;
    repeat (2) @(posedge iClk);
    #1;
    s = cyc;
    iRst_n = 1'b1;
    push(3'd1, 4'b0001, s + 1, "post_rst_r0_en");
    expect_next(5);
    push(3'd5, 4'b0000, last_cyc + 30, "post_rst_timeout");
    expect_next(40);
    check("post_rst_rail", bus.oFaultRail, 0);
    check("post_rst_fault", bus.oFault, 1);

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwr_seq_ctrl.md
Name: pwr_seq_ctrl

Overview:
- Power-rail sequencer for board-management logic.
- Brings NUM_RAILS rails up in index order. Each rail has a power-good timeout and a programmable post-good delay, both counted in 1 ms ticks from an internal tick generator.
- Brings rails down in reverse order on shutdown.
- Latches the failing rail on fault.
- Sits between the platform start/shutdown request logic and the regulator enable pins.

Parameters:
- multiplier, 2: iClk cycles per usec.
- UnitTime, 1000: usec per tick. TARGET = multiplier*UnitTime clocks per tick.
- NUM_RAILS, 4: number of sequenced rails, 2..8.
- DLY_W, 8: width of each per-rail delay field, in ms.
- TIMEOUT_MS, 10: ms allowed for a rail's power-good after its enable.

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  asynchronous active-low reset.
- iStart  in  1  level request to power up.
- iShutdown  in  1  level request to power down; also clears FAULT.
- iPwrGood  in  NUM_RAILS  per-rail power-good, synchronous to iClk.
- iDelayMs  in  NUM_RAILS*DLY_W  post-good delay per rail; rail i uses bits [i*DLY_W +: DLY_W].
- oRailEn  out  NUM_RAILS  registered rail enables.
- oSysPwrOk  out  1  high only in ON.
- oFault  out  1  high only in FAULT.
- oFaultRail  out  3  index of the rail that caused the fault.
- oState  out  3  encoded state: IDLE=0, RAMP=1, DELAY=2, ON=3, SHDN=4, FAULT=5.

Behaviour:
- Reset (iRst_n=0, asynchronous):
  - state=IDLE, rail index idx=0.
  - oRailEn=0, oSysPwrOk=0, oFault=0, oFaultRail=0.
  - Tick counter and ms counter cleared.
- Tick generator:
  - Counts 0..TARGET-1 and pulses tick for one cycle when at TARGET-1.
  - Exact period is TARGET clocks.
  - Tick counter and ms counter (width max(DLY_W,clog2(TIMEOUT_MS+1))) are cleared on every state or idx change, so each interval starts with a full ms.
  - ms counter increments on tick and saturates at all-ones.
- IDLE:
  - iStart=1 and iShutdown=0 -> RAMP with idx=0.
  - iShutdown has priority over iStart: stay in IDLE.
- RAMP:
  - oRailEn[idx]=1 from the first RAMP cycle.
  - iPwrGood[idx]=1 -> DELAY.
  - ms counter reaching TIMEOUT_MS with iPwrGood[idx]=0 -> FAULT with oFaultRail=idx. New state is visible on the edge after the TIMEOUT_MS-th tick, i.e. TIMEOUT_MS*TARGET clocks after RAMP entry.
- DELAY:
  - Leaves when ms count == iDelayMs[idx]. A delay of 0 means exactly one cycle in DELAY.
  - If idx==NUM_RAILS-1 -> ON; else idx+1 -> RAMP.
  - iDelayMs is sampled live; software must hold it stable during a sequence.
- ON:
  - oSysPwrOk=1, all oRailEn=1.
  - iStart deassertion alone has no effect.
- Rail-loss monitor:
  - Active in RAMP, DELAY and ON.
  - Watches every rail j whose good was already accepted (j<idx, or j==idx once in DELAY/ON).
  - iPwrGood[j]=0 -> FAULT with oFaultRail = lowest such j.
- Shutdown:
  - iShutdown=1 in RAMP, DELAY or ON -> SHDN.
  - SHDN starts at the highest enabled rail and clears one oRailEn bit per tick, highest first. The first bit clears on the first tick after entry.
  - Power-good is ignored in SHDN.
  - All oRailEn==0 -> IDLE, idx=0.
- FAULT:
  - oRailEn=0 on entry (same edge as the state change), oFault=1, oFaultRail held.
  - Leaves only when iShutdown=1 and iStart=0 -> IDLE. oFaultRail is retained in IDLE until the next RAMP entry, where it clears to 0.
- Simultaneous events:
  - Fault detection beats iShutdown in the same cycle.
  - Timeout and power-good arriving in the same cycle: power-good wins.
  - iStart during SHDN is ignored until IDLE is reached.
- Reset mid-sequence: all enables drop asynchronously.

Test Plan (multiplier=2, UnitTime=5 -> TARGET=10; NUM_RAILS=4, TIMEOUT_MS=3):
- Normal up: iDelayMs={2,1,0,3} (rail3..rail0), each good asserted 5 clocks after its enable, iStart=1 -> oRailEn goes 0001, 0011, 0111, 1111. Spacing from good to next enable is 30, 0(+1), 10 and 20 clocks; oSysPwrOk=1 one cycle after rail3 delay expires.
- Timeout: rail2 good never asserted -> oFault=1, oFaultRail=2, oRailEn=0 exactly 30 clocks after rail2 enable.
- Rail loss: in ON, drop iPwrGood[1] for 1 cycle -> FAULT, oFaultRail=1, oSysPwrOk=0 on the next edge.
- Shutdown from ON -> oRailEn 1111, 0111, 0011, 0001, 0000 at 10-clock steps, then IDLE.
- Priority: iStart=iShutdown=1 in IDLE -> stays IDLE. Fault clear with iShutdown=1 and iStart=0 -> IDLE; restart clears oFaultRail.
- Reset asserted mid-DELAY -> all outputs 0 immediately (asynchronous). After release, a new start yields full 10-clock tick spacing.
